req_ack_tracker: RTL

//  Synthesizable, multi-channel request/acknowledge checker.
//  - Tracks every rising edge of req per channel as an outstanding transaction.
//  - Matches each rising edge of ack to the oldest outstanding request (in order).
//  - Flags early, late (timeout), spurious and overflow violations.
//  - Sits beside handshake interfaces in the design and in the benches as a

---
 rtl/req_ack_tracker.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/req_ack_tracker.sv
// rtl/req_ack_tracker.sv - multi-channel request/acknowledge handshake monitor
//
// Purpose:
//   Each rising edge of req[ch] is queued as an outstanding transaction.
//   Each rising edge of ack[ch] retires the oldest one, in order.
//   Early, timed-out, spurious and overflowing handshakes are flagged.
//
// Ports:
//   clk, rst      clock (posedge); asynchronous active-high reset
//   req, ack      per-channel request / acknowledge levels
//   clear         synchronous clear of req_cnt, ack_cnt, err_any, lat_max
//   ack_ok        1-cycle pulse: ack matched within [MIN_LAT, MAX_LAT]
//   err_early     1-cycle pulse: ack matched with latency below MIN_LAT
//   err_timeout   1-cycle pulse: oldest request reached MAX_LAT without ack
//   err_spurious  1-cycle pulse: ack with nothing outstanding
//   err_overflow  1-cycle pulse: req while MAX_OUT requests outstanding
//   err_any       sticky OR of all error pulses
//   outstanding   per-channel outstanding count, OUT_W bits each
//   req_cnt       per-channel req rising-edge count, CNT_W bits each
//   ack_cnt       per-channel ack rising-edge count, CNT_W bits each
//   lat_max       per-channel max matched latency, LAT_W bits each
//
// Build option:
//   LAT_STATS_EN  when defined, lat_max tracks the largest ack_ok latency;
//                 otherwise lat_max is tied to zero.
module req_ack_tracker #(
    parameter int NUM_CH  = 4,
    parameter int MAX_OUT = 4,
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 7,
    parameter int CNT_W   = 8,
    parameter int OUT_W   = $clog2(MAX_OUT + 1),
    parameter int LAT_W   = $clog2(MAX_LAT + 2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       ack,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       ack_ok,
    output logic [NUM_CH-1:0]       err_early,
    output logic [NUM_CH-1:0]       err_timeout,
    output logic [NUM_CH-1:0]       err_spurious,
    output logic [NUM_CH-1:0]       err_overflow,
    output logic                    err_any,
    output logic [NUM_CH*OUT_W-1:0] outstanding,
    output logic [NUM_CH*CNT_W-1:0] req_cnt,
    output logic [NUM_CH*CNT_W-1:0] ack_cnt,
    output logic [NUM_CH*LAT_W-1:0] lat_max
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [LAT_W-1:0] MIN_L    = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L    = LAT_W'(MAX_LAT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);
    localparam logic [OUT_W-1:0] FULL_CNT = OUT_W'(MAX_OUT);

    logic [NUM_CH-1:0] req_q, req_d;
    logic [NUM_CH-1:0] ack_q, ack_d;

    logic [LAT_W-1:0]  age_q [NUM_CH][MAX_OUT];
    logic [LAT_W-1:0]  age_d [NUM_CH][MAX_OUT];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [OUT_W-1:0]  count_q [NUM_CH];
    logic [OUT_W-1:0]  count_d [NUM_CH];
    logic [CNT_W-1:0]  req_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  req_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  ack_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  ack_cnt_d [NUM_CH];

    logic [NUM_CH-1:0] ack_ok_q, ack_ok_d;
    logic [NUM_CH-1:0] err_early_q, err_early_d;
    logic [NUM_CH-1:0] err_timeout_q, err_timeout_d;
    logic [NUM_CH-1:0] err_spurious_q, err_spurious_d;
    logic [NUM_CH-1:0] err_overflow_q, err_overflow_d;
    logic              err_any_q, err_any_d;

    logic [NUM_CH-1:0] req_rise, ack_rise;
    logic [NUM_CH-1:0] ack_pop, tmo_pop, do_pop, do_push;
    logic [LAT_W-1:0]  oldest_age [NUM_CH];

    // Event decode: the age at rd_ptr is the latency of the oldest request
    // as seen at this edge, since a push stores 1 and every edge adds 1.
    always_comb begin
        req_d          = req;
        ack_d          = ack;
        req_rise       = '0;
        ack_rise       = '0;
        ack_pop        = '0;
        tmo_pop        = '0;
        do_pop         = '0;
        do_push        = '0;
        ack_ok_d       = '0;
        err_early_d    = '0;
        err_timeout_d  = '0;
        err_spurious_d = '0;
        err_overflow_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            oldest_age[ch] = age_q[ch][rd_ptr_q[ch]];
            req_rise[ch]   = req[ch] & ~req_q[ch];
            ack_rise[ch]   = ack[ch] & ~ack_q[ch];
            // An ack always takes precedence over a timeout of the same entry,
            // which makes an ack at exactly MAX_LAT legal.
            ack_pop[ch]    = ack_rise[ch] & (count_q[ch] != '0);
            tmo_pop[ch]    = ~ack_rise[ch] & (count_q[ch] != '0) & (oldest_age[ch] >= MAX_L);
            do_pop[ch]     = ack_pop[ch] | tmo_pop[ch];
            // A pop in the same cycle frees a slot before the push is judged.
            do_push[ch]    = req_rise[ch] & ((count_q[ch] != FULL_CNT) | do_pop[ch]);

            ack_ok_d[ch]       = ack_pop[ch] & (oldest_age[ch] >= MIN_L) & (oldest_age[ch] <= MAX_L);
            err_early_d[ch]    = ack_pop[ch] & (oldest_age[ch] < MIN_L);
            err_timeout_d[ch]  = tmo_pop[ch];
            err_spurious_d[ch] = ack_rise[ch] & (count_q[ch] == '0);
            err_overflow_d[ch] = req_rise[ch] & ~do_push[ch];
        end
    end

    // Buffer, counter and sticky-error next state.
    always_comb begin
        age_d    = age_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            // Free slots age too; their contents are never read.
            for (int i = 0; i < MAX_OUT; i++) begin
                age_d[ch][i] = age_q[ch][i] + LAT_W'(1);
            end
            if (do_pop[ch]) begin
                rd_ptr_d[ch] = (rd_ptr_q[ch] == LAST_PTR) ? '0 : rd_ptr_q[ch] + PTR_W'(1);
            end
            if (do_push[ch]) begin
                age_d[ch][wr_ptr_q[ch]] = LAT_W'(1);
                wr_ptr_d[ch] = (wr_ptr_q[ch] == LAST_PTR) ? '0 : wr_ptr_q[ch] + PTR_W'(1);
            end
            count_d[ch]   = count_q[ch] + OUT_W'(do_push[ch]) - OUT_W'(do_pop[ch]);
            // Clear zeroes the base; an event in the same cycle is still counted.
            req_cnt_d[ch] = (clear ? '0 : req_cnt_q[ch]) + CNT_W'(req_rise[ch]);
            ack_cnt_d[ch] = (clear ? '0 : ack_cnt_q[ch]) + CNT_W'(ack_rise[ch]);
        end
        err_any_d = clear ? 1'b0 : err_any_q;
        if ((err_early_d | err_timeout_d | err_spurious_d | err_overflow_d) != '0) begin
            err_any_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q          <= '0;
            ack_q          <= '0;
            ack_ok_q       <= '0;
            err_early_q    <= '0;
            err_timeout_q  <= '0;
            err_spurious_q <= '0;
            err_overflow_q <= '0;
            err_any_q      <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rd_ptr_q[ch]  <= '0;
                wr_ptr_q[ch]  <= '0;
                count_q[ch]   <= '0;
                req_cnt_q[ch] <= '0;
                ack_cnt_q[ch] <= '0;
                for (int i = 0; i < MAX_OUT; i++) begin
                    age_q[ch][i] <= '0;
                end
            end
        end else begin
            req_q          <= req_d;
            ack_q          <= ack_d;
            ack_ok_q       <= ack_ok_d;
            err_early_q    <= err_early_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
            err_overflow_q <= err_overflow_d;
            err_any_q      <= err_any_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            req_cnt_q      <= req_cnt_d;
            ack_cnt_q      <= ack_cnt_d;
            age_q          <= age_d;
        end
    end

    assign ack_ok       = ack_ok_q;
    assign err_early    = err_early_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;
    assign err_overflow = err_overflow_q;
    assign err_any      = err_any_q;

    always_comb begin
        outstanding = '0;
        req_cnt     = '0;
        ack_cnt     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            outstanding[ch*OUT_W +: OUT_W] = count_q[ch];
            req_cnt[ch*CNT_W +: CNT_W]     = req_cnt_q[ch];
            ack_cnt[ch*CNT_W +: CNT_W]     = ack_cnt_q[ch];
        end
    end

`ifdef LAT_STATS_EN
    logic [LAT_W-1:0] lat_max_q [NUM_CH];
    logic [LAT_W-1:0] lat_max_d [NUM_CH];

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            lat_max_d[ch] = clear ? '0 : lat_max_q[ch];
            if (ack_ok_d[ch] && (oldest_age[ch] > lat_max_d[ch])) begin
                lat_max_d[ch] = oldest_age[ch];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                lat_max_q[ch] <= '0;
            end
        end else begin
            lat_max_q <= lat_max_d;
        end
    end

    always_comb begin
        lat_max = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            lat_max[ch*LAT_W +: LAT_W] = lat_max_q[ch];
        end
    end
`else
    assign lat_max = '0;
`endif

endmodule
